// File: rtl/fetch_align_stage.sv
// Instruction-fetch front end: drives program-memory word addresses, buffers words as halfwords
// and realigns 16/32-bit instructions for decode. Compressed support is enabled by FETCH_RVC_EN.
module fetch_align_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pmAddr,
   input  logic [31:0] pmData,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_compressed
);
   localparam int QDEPTH = 6;

`ifdef FETCH_RVC_EN
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
   localparam logic [31:0] RESET_PC_EFF = RESET_PC & PC_MASK;
   localparam logic [31:0] RESET_ADDR   = RESET_PC & 32'hFFFF_FFFC;

   logic [15:0] hq_q [QDEPTH];
   logic [15:0] hq_d [QDEPTH];
   logic [2:0]  count_q, count_d;
   logic        req_q, req_d;
   logic [31:0] pm_addr_q, pm_addr_d;
   logic [31:0] pc_q, pc_d;
`ifdef FETCH_RVC_EN
   logic        skip_lo_q, skip_lo_d;
`endif

   logic        head_compressed_s;
   logic        head_ready_s;
   logic        id_valid_s;
   logic        fire_s;
   logic [1:0]  pop_n_s;
   logic [2:0]  base_s;
   logic        issue_s;

   // Head decode: instruction length at the queue head and whether all its halfwords are present.
   always_comb begin
`ifdef FETCH_RVC_EN
      head_compressed_s = (hq_q[0][1:0] != 2'b11);
`else
      head_compressed_s = 1'b0;
`endif
      if (head_compressed_s) begin
         head_ready_s = (count_q >= 3'd1);
      end else begin
         head_ready_s = (count_q >= 3'd2);
      end
   end

   // Decode-side outputs come straight from the queue head, so they hold while decode stalls.
   always_comb begin
      id_valid_s    = head_ready_s & ~redirect_valid;
      id_instr      = 32'h0000_0000;
      id_compressed = 1'b0;
      if (id_valid_s) begin
         if (head_compressed_s) begin
            id_instr      = {16'h0000, hq_q[0]};
            id_compressed = 1'b1;
         end else begin
            id_instr      = {hq_q[1], hq_q[0]};
            id_compressed = 1'b0;
         end
      end else begin
         id_instr      = 32'h0000_0000;
         id_compressed = 1'b0;
      end
   end

   assign id_valid = id_valid_s;
   assign id_pc    = pc_q;
   assign pmAddr   = pm_addr_q;

   // Handshake and flow control: pop size, post-pop fill level and request eligibility.
   always_comb begin
      fire_s = id_valid_s & id_ready;
      if (fire_s) begin
         if (head_compressed_s) begin
            pop_n_s = 2'd1;
         end else begin
            pop_n_s = 2'd2;
         end
      end else begin
         pop_n_s = 2'd0;
      end
      base_s  = count_q - {1'b0, pop_n_s};
      // Pre-pop count guarantees room for both the in-flight and the new response.
      issue_s = (({1'b0, count_q} + {2'b00, req_q, 1'b0}) <= 4'd4);
   end

   // Halfword queue next state: shift out popped entries, append the captured word behind them.
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < QDEPTH; i++) begin
         hq_d[i] = hq_q[i];
      end
`ifdef FETCH_RVC_EN
      skip_lo_d = skip_lo_q;
`endif
      if (redirect_valid) begin
         count_d = 3'd0;
`ifdef FETCH_RVC_EN
         skip_lo_d = redirect_pc[1];
`endif
      end else begin
         case (pop_n_s)
            2'd1: begin
               for (int i = 0; i < QDEPTH - 1; i++) begin
                  hq_d[i] = hq_q[i + 1];
               end
            end
            2'd2: begin
               for (int i = 0; i < QDEPTH - 2; i++) begin
                  hq_d[i] = hq_q[i + 2];
               end
            end
            default: begin
               for (int i = 0; i < QDEPTH; i++) begin
                  hq_d[i] = hq_q[i];
               end
            end
         endcase
         if (req_q) begin
`ifdef FETCH_RVC_EN
            skip_lo_d = 1'b0;
            if (skip_lo_q) begin
               hq_d[base_s] = pmData[31:16];
               count_d      = base_s + 3'd1;
            end else begin
               hq_d[base_s]        = pmData[15:0];
               hq_d[base_s + 3'd1] = pmData[31:16];
               count_d             = base_s + 3'd2;
            end
`else
            hq_d[base_s]        = pmData[15:0];
            hq_d[base_s + 3'd1] = pmData[31:16];
            count_d             = base_s + 3'd2;
`endif
         end else begin
            count_d = base_s;
         end
      end
   end

   // Fetch address, request flag and instruction PC next state; a redirect overrides both.
   always_comb begin
      pm_addr_d = pm_addr_q;
      req_d     = 1'b0;
      pc_d      = pc_q;
      if (redirect_valid) begin
         pm_addr_d = redirect_pc & 32'hFFFF_FFFC;
         req_d     = 1'b0;
         pc_d      = redirect_pc & PC_MASK;
      end else begin
         if (issue_s) begin
            req_d     = 1'b1;
            pm_addr_d = pm_addr_q + 32'd4;
         end else begin
            req_d     = 1'b0;
            pm_addr_d = pm_addr_q;
         end
         if (fire_s) begin
            pc_d = pc_q + (head_compressed_s ? 32'd2 : 32'd4);
         end else begin
            pc_d = pc_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pm_addr_q <= RESET_ADDR;
         pc_q      <= RESET_PC_EFF;
         count_q   <= 3'd0;
         req_q     <= 1'b0;
`ifdef FETCH_RVC_EN
         skip_lo_q <= RESET_PC[1];
`endif
         for (int i = 0; i < QDEPTH; i++) begin
            hq_q[i] <= 16'h0000;
         end
      end else begin
         pm_addr_q <= pm_addr_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         req_q     <= req_d;
`ifdef FETCH_RVC_EN
         skip_lo_q <= skip_lo_d;
`endif
         for (int i = 0; i < QDEPTH; i++) begin
            hq_q[i] <= hq_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fetch_align_stage.sv
// Bench for fetch_align_stage: directed timing steps plus a randomized stream checked against an
// in-order instruction model that walks memory by PC.
module tb_fetch_align_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_RVC_EN
   localparam logic [31:0] MASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] MASK = 32'hFFFF_FFFC;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pmAddr;
   logic [31:0] pmData = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_compressed;

   logic [31:0] mem [1024];
   int          checks = 0;
   int          errors = 0;
   int          xfers  = 0;
   logic [31:0] model_pc;
   logic        s_valid, s_c;
   logic [31:0] s_instr, s_pc, s_addr;

   fetch_align_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .pmAddr(pmAddr), .pmData(pmData),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_compressed(id_compressed)
   );

   always #5 clk = ~clk;

   // Program memory: fixed one-cycle read latency.
   always @(posedge clk) pmData <= mem[pmAddr[11:2]];

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[11:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      logic [31:0] e_instr, nxt;
      logic        e_c;
      logic [15:0] h0;
      rst = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      @(negedge clk);
      s_valid = id_valid; s_instr = id_instr; s_pc = id_pc; s_c = id_compressed; s_addr = pmAddr;
      chk("pmaddr_align", {30'd0, pmAddr[1:0]}, 32'd0);
      if (!id_valid) begin
         chk("idle_instr", id_instr, 32'd0);
         chk("idle_c", 32'(id_compressed), 32'd0);
      end else begin
         chk("valid_during_redirect", 32'(rv), 32'd0);
         if (rdy && !r) begin
`ifdef FETCH_RVC_EN
            h0 = hw_at(model_pc);
            if (h0[1:0] != 2'b11) begin
               e_instr = {16'h0000, h0}; e_c = 1'b1; nxt = model_pc + 32'd2;
            end else begin
               e_instr = {hw_at(model_pc + 32'd2), h0}; e_c = 1'b0; nxt = model_pc + 32'd4;
            end
`else
            h0 = 16'h0000;
            e_instr = mem[model_pc[11:2]]; e_c = 1'b0; nxt = model_pc + 32'd4;
`endif
            chk("xfer_pc", id_pc, model_pc);
            chk("xfer_instr", id_instr, e_instr);
            chk("xfer_c", 32'(id_compressed), 32'(e_c));
            model_pc = nxt;
            xfers++;
         end
      end
      if (r) model_pc = RST_PC;
      else if (rv) model_pc = rpc & MASK;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] st_instr, st_pc, a0, tmp, rpc;
      int          rand_start;
      rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      model_pc = RST_PC;
      for (int i = 0; i < 1024; i++) begin
         tmp = i;
         mem[i] = {tmp[15:0], 16'h0013};
      end
      mem[64] = 32'h0000_0013;

      // Reset latency: address in cycle 0, first instruction in cycle 2.
      run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("c0_pmaddr", s_addr, 32'h100);
      chk("c0_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("c1_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("c2_valid", 32'(s_valid), 32'd1);
      chk("c2_pc", s_pc, 32'h100);
      chk("c2_instr", s_instr, 32'h0000_0013);
      chk("c2_c", 32'(s_c), 32'd0);
      for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // Decode stall: outputs hold, fetch stops one word later.
      run_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      st_instr = s_instr; st_pc = s_pc; a0 = s_addr;
      chk("stall_valid", 32'(s_valid), 32'd1);
      for (int k = 1; k < 10; k++) begin
         run_cycle(1'b0, 1'b0, 1'b0, 32'd0);
         chk("stall_hold_valid", 32'(s_valid), 32'd1);
         chk("stall_hold_pc", s_pc, st_pc);
         chk("stall_hold_instr", s_instr, st_instr);
      end
      chk("stall_pmaddr", s_addr, a0 + 32'd4);
      for (int k = 0; k < 10; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // Redirect to 0x202 with a response in flight.
      mem[128] = 32'h4501_FFFF;
      mem[129] = 32'h0000_0013;
      run_cycle(1'b0, 1'b1, 1'b1, 32'h202);
      chk("redir_t0_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_t1_pmaddr", s_addr, 32'h200);
      chk("redir_t1_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_t2_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_t3_valid", 32'(s_valid), 32'd1);
`ifdef FETCH_RVC_EN
      chk("redir_t3_pc", s_pc, 32'h202);
      chk("redir_t3_instr", s_instr, 32'h0000_4501);
      chk("redir_t3_c", 32'(s_c), 32'd1);
`else
      chk("redir_t3_pc", s_pc, 32'h200);
      chk("redir_t3_instr", s_instr, 32'h4501_FFFF);
      chk("redir_t3_c", 32'(s_c), 32'd0);
`endif
      for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // One-cycle reset mid-stream.
      run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      chk("rst_pre_valid", 32'(s_valid), 32'd1);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("rst_r1_valid", 32'(s_valid), 32'd0);
      chk("rst_r1_pmaddr", s_addr, 32'h100);
      chk("rst_r1_pc", s_pc, 32'h100);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("rst_r2_valid", 32'(s_valid), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("rst_r3_valid", 32'(s_valid), 32'd1);
      chk("rst_r3_pc", s_pc, 32'h100);

      // Mixed 16/32-bit stream with a straddling instruction.
      mem[64] = 32'h0513_4501;
      mem[65] = 32'h8082_0000;
      run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
`ifdef FETCH_RVC_EN
      chk("mix0_pc", s_pc, 32'h100);  chk("mix0_instr", s_instr, 32'h0000_4501);
      chk("mix0_c", 32'(s_c), 32'd1);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mix1_pc", s_pc, 32'h102);  chk("mix1_instr", s_instr, 32'h0000_0513);
      chk("mix1_c", 32'(s_c), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mix2_pc", s_pc, 32'h106);  chk("mix2_instr", s_instr, 32'h0000_8082);
      chk("mix2_c", 32'(s_c), 32'd1);
`else
      chk("mix0_pc", s_pc, 32'h100);  chk("mix0_instr", s_instr, 32'h0513_4501);
      chk("mix0_c", 32'(s_c), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mix1_pc", s_pc, 32'h104);  chk("mix1_instr", s_instr, 32'h8082_0000);
      chk("mix1_c", 32'(s_c), 32'd0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mix2_pc", s_pc, 32'h108);  chk("mix2_instr", s_instr, 32'h0042_0013);
      chk("mix2_c", 32'(s_c), 32'd0);
`endif

      // Randomized program, stalls, redirects and resets against the in-order model.
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      rand_start = xfers;
      for (int k = 0; k < 3000; k++) begin
         tmp = $urandom;
         rpc = {20'd0, tmp[11:1], 1'b0};
         run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 39) == 0, rpc);
      end
      chk("rand_progress", 32'((xfers - rand_start) > 1200), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
